ethernet_rx: RTL
================

# ethernet_rx

RMII receive engine for the Ethernet MAC; the counterpart of the transmit engine. It samples 2-bit RMII dibits on a 50 MHz sample strobe, strips preamble and SFD, and filters on destination address. It streams payload bytes into the RX payload buffer and checks the FCS with the shared CRC-32 engine. At end of frame it posts a descriptor (source address, length, error flags) to the RX descriptor queue.

## Interface
- `MAC_ADDRESS`, default `48'hFF_FF_FF_FF_FF_FF`: station address accepted by the filter, in addition to broadcast.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `receive_i` in 1: RMII sample strobe. One dibit is consumed per cycle in which it is high.
- `rmii_rxd_i` in 2: RMII receive data. LSB dibit of each byte arrives first.
- `rmii_crsdv_i` in 1: RMII carrier sense / data valid.
- `payload_data_o` out 8: received payload byte.
- `write_data_o` out 1: one-cycle pulse that pushes `payload_data_o` into the payload buffer.
- `write_descriptor_o` out 1: one-cycle pulse that pushes the descriptor fields below.
- `src_address_o` out 48: source MAC address of the frame. Byte received first is `[5]`.
- `payload_length_o` out 16: length field of the frame. Byte received first is `[15:8]`.
- `crc_error_o` out 1: FCS mismatch.
- `frame_error_o` out 1: carrier lost before the FCS completed, or length > 1500.
- `idle_o` out 1: high in IDLE.

## Operation
- Byte assembly: on each strobe, `shift <= {rxd, shift[7:2]}`. A 2-bit dibit counter wraps at 3, and the byte is complete on the 4th dibit.
- FSM states: IDLE, PREAMBLE, MAC_DESTINATION, MAC_SOURCE, ETH_TYPE, PAYLOAD, PADDING, FRAME_CHECK_SEQUENCE, DROP.
- IDLE: on strobe with `crsdv=1` and `rxd=2'b10`, go to PREAMBLE. CRC engine initialised. Counters cleared.
- PREAMBLE: `rxd=2'b10` stays. `rxd=2'b11` goes to MAC_DESTINATION with dibit counter at 0. Any other value goes to DROP.
- MAC_DESTINATION (6 bytes): compare each byte against `MAC_ADDRESS` and against `8'hFF`. After byte 5, if neither matched over all bytes, go to DROP.
- MAC_SOURCE (6 bytes): bytes captured into `src_address_o` working register.
- ETH_TYPE (2 bytes): captured into the length register. Length > 1500 sets frame error and goes to DROP after the descriptor is posted.
- PAYLOAD: each byte drives `payload_data_o` and pulses `write_data_o`.
  - After `length` bytes: if length < 46, go to PADDING; else go to FRAME_CHECK_SEQUENCE.
  - Length 0 goes directly from ETH_TYPE to PADDING.
- PADDING: consume `46 - length` bytes. No writes. Bytes are included in the CRC.
- CRC coverage: every completed byte from the first destination byte through the last payload/pad byte is fed to `ethernet_crc32` (`compute_i` pulsed).
- FRAME_CHECK_SEQUENCE: capture 4 bytes. Byte k is compared with `crc32[3-k]`, sampled before FCS bytes arrive.
  - After byte 3: load `crc_error_o`, pulse `write_descriptor_o`, go to DROP.
- DROP: ignore dibits until `crsdv=0` on a strobe, then go to IDLE. No writes.
- Carrier loss (`crsdv=0` on a strobe) in MAC_SOURCE..FRAME_CHECK_SEQUENCE: set `frame_error_o`, pulse `write_descriptor_o`, go to IDLE.
- Carrier loss in MAC_DESTINATION or PREAMBLE: return to IDLE silently.
- Descriptor outputs hold their value until the next `write_descriptor_o`.

## Timing
- Reset: state IDLE; `write_data_o`, `write_descriptor_o`, `crc_error_o`, `frame_error_o` = 0; `src_address_o`, `payload_length_o`, `payload_data_o` = 0; `idle_o` = 1.
- Outputs are registered. `write_data_o` is asserted in the cycle after the strobe carrying the 4th dibit of the byte.
- `write_descriptor_o` is asserted in the cycle after the terminating strobe. Descriptor fields are valid in that same cycle.
- `write_data_o` and `write_descriptor_o` are never asserted together.
- No backpressure: the sinks always accept. Byte-rate spacing (≥4 strobes) guarantees at most one push per 4 cycles.
- `rst_i` mid-frame: immediate return to IDLE. No descriptor is posted. The partial payload already pushed is the sink's concern.
- Strobes with `receive_i=0` freeze all state.

## Structure
- `ethernet_pkg` holds the existing `PREAMBLE_BYTES`, `MAC_ADDR_BYTES`, `ETH_TYPE_BYTES`, `CRC_BYTES`, plus new `MIN_PAYLOAD_BYTES=46`, `MAX_PAYLOAD_BYTES=1500`, and the `ethernet_rx_states_t` enum.
- Sub-module: reuse `ethernet_crc32` unchanged. No other sub-modules.

## Test plan
- Unicast frame to `MAC_ADDRESS`, length 64, correct FCS:
  - 64 `write_data_o` pulses with the bytes in order.
  - One descriptor with length 64, both errors 0.
  - Source address matches the sent source.
- Broadcast frame, length 10, correct FCS:
  - 10 writes; 36 pad bytes consumed without writes.
  - Descriptor `crc_error_o=0`.
- Frame to another address: zero writes, no descriptor, `idle_o` returns high after `crsdv` falls.
- Unicast frame, length 100, with one FCS bit flipped: 100 writes, descriptor `crc_error_o=1`.
- `crsdv` dropped after payload byte 20 of 100: 20 writes, descriptor `frame_error_o=1`, state IDLE.
- Length field 1600: no payload writes; descriptor `frame_error_o=1`. Also assert `rst_i` mid-payload: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ethernet_pkg.sv
// Shared Ethernet MAC constants, receive FSM states and the RX descriptor payload.
package ethernet_pkg;

  localparam int unsigned PREAMBLE_BYTES    = 7;
  localparam int unsigned MAC_ADDR_BYTES    = 6;
  localparam int unsigned ETH_TYPE_BYTES    = 2;
  localparam int unsigned CRC_BYTES         = 4;
  localparam int unsigned MIN_PAYLOAD_BYTES = 46;
  localparam int unsigned MAX_PAYLOAD_BYTES = 1500;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    MAC_DESTINATION,
    MAC_SOURCE,
    ETH_TYPE,
    PAYLOAD,
    PADDING,
    FRAME_CHECK_SEQUENCE,
    DROP
  } ethernet_rx_states_t;

  typedef struct packed {
    logic [47:0] src_address;
    logic [15:0] payload_length;
    logic        crc_error;
    logic        frame_error;
  } rx_desc_t;

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide reflected CRC-32 (IEEE 802.3). crc_o[31:24] is the first FCS byte on the wire.
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        compute_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (compute_i) begin
      crc_d = crc_step(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Final complement, byte-ordered so the first transmitted FCS byte sits on top.
  assign crc_o = ~{crc_q[7:0], crc_q[15:8], crc_q[23:16], crc_q[31:24]};

endmodule

// File: rtl/ethernet_rx.sv
// RMII receive engine: dibit assembly, destination filter, payload streaming,
// FCS check and descriptor posting.
module ethernet_rx
  import ethernet_pkg::*;
#(
  parameter logic [47:0] MAC_ADDRESS = 48'hFF_FF_FF_FF_FF_FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        receive_i,
  input  logic [1:0]  rmii_rxd_i,
  input  logic        rmii_crsdv_i,
  output logic [7:0]  payload_data_o,
  output logic        write_data_o,
  output logic        write_descriptor_o,
  output logic [47:0] src_address_o,
  output logic [15:0] payload_length_o,
  output logic        crc_error_o,
  output logic        frame_error_o,
  output logic        idle_o
);

  localparam logic [1:0]  DIBIT_PREAMBLE = 2'b10;
  localparam logic [1:0]  DIBIT_SFD      = 2'b11;
  localparam logic [15:0] MAC_LAST       = 16'(MAC_ADDR_BYTES - 1);
  localparam logic [15:0] TYPE_LAST      = 16'(ETH_TYPE_BYTES - 1);
  localparam logic [15:0] CRC_LAST       = 16'(CRC_BYTES - 1);
  localparam logic [15:0] MIN_LEN        = 16'(MIN_PAYLOAD_BYTES);
  localparam logic [15:0] MAX_LEN        = 16'(MAX_PAYLOAD_BYTES);

  ethernet_rx_states_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  dibit_cnt_q, dibit_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        uc_match_q, uc_match_d;
  logic        bc_match_q, bc_match_d;
  logic [47:0] src_q, src_d;
  logic [15:0] len_q, len_d;
  logic        fcs_bad_q, fcs_bad_d;
  logic [7:0]  payload_data_q, payload_data_d;
  logic        write_data_q, write_data_d;
  logic        write_desc_q, write_desc_d;
  rx_desc_t    desc_q, desc_d;
  logic        idle_q;

  logic [7:0]  rx_byte_c;
  logic        byte_done_c;
  logic [15:0] byte_cnt_inc_c;
  logic [15:0] len_next_c;
  logic        in_frame_c;
  logic [7:0]  mac_byte_c;
  logic [7:0]  crc_ref_c;
  logic [31:0] crc_c;
  logic        crc_init_c;
  logic        crc_compute_c;

  assign rx_byte_c      = {rmii_rxd_i, shift_q[7:2]};
  assign byte_done_c    = (dibit_cnt_q == 2'd3);
  assign byte_cnt_inc_c = byte_cnt_q + 16'd1;
  assign len_next_c     = {len_q[7:0], rx_byte_c};
  assign in_frame_c     = state_q inside {MAC_SOURCE, ETH_TYPE, PAYLOAD, PADDING,
                                          FRAME_CHECK_SEQUENCE};
  assign crc_init_c     = (state_q == IDLE);

  // Station address byte expected at the current destination position, first byte = [47:40].
  always_comb begin
    unique case (byte_cnt_q[2:0])
      3'd0:    mac_byte_c = MAC_ADDRESS[47:40];
      3'd1:    mac_byte_c = MAC_ADDRESS[39:32];
      3'd2:    mac_byte_c = MAC_ADDRESS[31:24];
      3'd3:    mac_byte_c = MAC_ADDRESS[23:16];
      3'd4:    mac_byte_c = MAC_ADDRESS[15:8];
      default: mac_byte_c = MAC_ADDRESS[7:0];
    endcase
  end

  always_comb begin
    unique case (byte_cnt_q[1:0])
      2'd0:    crc_ref_c = crc_c[31:24];
      2'd1:    crc_ref_c = crc_c[23:16];
      2'd2:    crc_ref_c = crc_c[15:8];
      default: crc_ref_c = crc_c[7:0];
    endcase
  end

  ethernet_crc32 u_crc32 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .init_i    (crc_init_c),
    .compute_i (crc_compute_c),
    .data_i    (rx_byte_c),
    .crc_o     (crc_c)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    dibit_cnt_d    = dibit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    uc_match_d     = uc_match_q;
    bc_match_d     = bc_match_q;
    src_d          = src_q;
    len_d          = len_q;
    fcs_bad_d      = fcs_bad_q;
    payload_data_d = payload_data_q;
    write_data_d   = 1'b0;
    write_desc_d   = 1'b0;
    desc_d         = desc_q;
    crc_compute_c  = 1'b0;

    if (receive_i) begin
      shift_d     = rx_byte_c;
      dibit_cnt_d = dibit_cnt_q + 2'd1;

      if (!rmii_crsdv_i && in_frame_c) begin
        // Carrier lost after the filter passed: report a truncated frame.
        write_desc_d = 1'b1;
        desc_d       = '{src_address: src_q, payload_length: len_q,
                         crc_error: 1'b0, frame_error: 1'b1};
        state_d      = IDLE;
      end else if (!rmii_crsdv_i) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rmii_rxd_i == DIBIT_PREAMBLE) begin
              state_d     = PREAMBLE;
              dibit_cnt_d = '0;
              byte_cnt_d  = '0;
            end
          end

          PREAMBLE: begin
            dibit_cnt_d = '0;
            byte_cnt_d  = '0;
            uc_match_d  = 1'b1;
            bc_match_d  = 1'b1;
            src_d       = '0;
            len_d       = '0;
            fcs_bad_d   = 1'b0;
            if (rmii_rxd_i == DIBIT_SFD) begin
              state_d = MAC_DESTINATION;
            end else if (rmii_rxd_i != DIBIT_PREAMBLE) begin
              state_d = DROP;
            end
          end

          MAC_DESTINATION: begin
            if (byte_done_c) begin
              crc_compute_c = 1'b1;
              uc_match_d    = uc_match_q && (rx_byte_c == mac_byte_c);
              bc_match_d    = bc_match_q && (rx_byte_c == 8'hFF);
              byte_cnt_d    = byte_cnt_inc_c;
              if (byte_cnt_q == MAC_LAST) begin
                byte_cnt_d = '0;
                state_d    = (uc_match_d || bc_match_d) ? MAC_SOURCE : DROP;
              end
            end
          end

          MAC_SOURCE: begin
            if (byte_done_c) begin
              crc_compute_c = 1'b1;
              src_d         = {src_q[39:0], rx_byte_c};
              byte_cnt_d    = byte_cnt_inc_c;
              if (byte_cnt_q == MAC_LAST) begin
                byte_cnt_d = '0;
                state_d    = ETH_TYPE;
              end
            end
          end

          ETH_TYPE: begin
            if (byte_done_c) begin
              crc_compute_c = 1'b1;
              len_d         = len_next_c;
              byte_cnt_d    = byte_cnt_inc_c;
              if (byte_cnt_q == TYPE_LAST) begin
                byte_cnt_d = '0;
                if (len_next_c > MAX_LEN) begin
                  write_desc_d = 1'b1;
                  desc_d       = '{src_address: src_q, payload_length: len_next_c,
                                   crc_error: 1'b0, frame_error: 1'b1};
                  state_d      = DROP;
                end else if (len_next_c == '0) begin
                  state_d = PADDING;
                end else begin
                  state_d = PAYLOAD;
                end
              end
            end
          end

          PAYLOAD: begin
            if (byte_done_c) begin
              crc_compute_c  = 1'b1;
              write_data_d   = 1'b1;
              payload_data_d = rx_byte_c;
              byte_cnt_d     = byte_cnt_inc_c;
              // The byte counter keeps running through padding up to the minimum size.
              if (byte_cnt_inc_c == len_q) begin
                if (len_q < MIN_LEN) begin
                  state_d = PADDING;
                end else begin
                  byte_cnt_d = '0;
                  state_d    = FRAME_CHECK_SEQUENCE;
                end
              end
            end
          end

          PADDING: begin
            if (byte_done_c) begin
              crc_compute_c = 1'b1;
              byte_cnt_d    = byte_cnt_inc_c;
              if (byte_cnt_inc_c == MIN_LEN) begin
                byte_cnt_d = '0;
                state_d    = FRAME_CHECK_SEQUENCE;
              end
            end
          end

          FRAME_CHECK_SEQUENCE: begin
            if (byte_done_c) begin
              fcs_bad_d  = fcs_bad_q || (rx_byte_c != crc_ref_c);
              byte_cnt_d = byte_cnt_inc_c;
              if (byte_cnt_q == CRC_LAST) begin
                write_desc_d = 1'b1;
                desc_d       = '{src_address: src_q, payload_length: len_q,
                                 crc_error: fcs_bad_d, frame_error: 1'b0};
                state_d      = DROP;
              end
            end
          end

          DROP: begin
            state_d = DROP;
          end

          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      dibit_cnt_q    <= '0;
      byte_cnt_q     <= '0;
      uc_match_q     <= 1'b0;
      bc_match_q     <= 1'b0;
      src_q          <= '0;
      len_q          <= '0;
      fcs_bad_q      <= 1'b0;
      payload_data_q <= '0;
      write_data_q   <= 1'b0;
      write_desc_q   <= 1'b0;
      desc_q         <= '0;
      idle_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      dibit_cnt_q    <= dibit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      uc_match_q     <= uc_match_d;
      bc_match_q     <= bc_match_d;
      src_q          <= src_d;
      len_q          <= len_d;
      fcs_bad_q      <= fcs_bad_d;
      payload_data_q <= payload_data_d;
      write_data_q   <= write_data_d;
      write_desc_q   <= write_desc_d;
      desc_q         <= desc_d;
      idle_q         <= (state_d == IDLE);
    end
  end

  assign payload_data_o     = payload_data_q;
  assign write_data_o       = write_data_q;
  assign write_descriptor_o = write_desc_q;
  assign src_address_o      = desc_q.src_address;
  assign payload_length_o   = desc_q.payload_length;
  assign crc_error_o        = desc_q.crc_error;
  assign frame_error_o      = desc_q.frame_error;
  assign idle_o             = idle_q;

endmodule
